xaui_mgmt_master: RTL and testbench

Avalon-MM initiator that drives the `phy_mgmt_*` management port of the XAUI PHY. It accepts single read/write/poll commands from local control logic and runs the bus handshake, including waitrequest stalls. It provides polling, with mask/compare and a bounded retry count, for PHY status bits such as ready and lock. It sits in the `phy_mgmt_clk` domain between the board control FSM and the PHY's 9-bit register space.

---
 rtl/xaui_mgmt_pkg.sv | 21 ++
 rtl/xaui_mgmt_master.sv | 189 ++++++++++++++++++
 tb/tb_xaui_mgmt_master.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xaui_mgmt_pkg.sv
// Shared types and constants for the XAUI PHY management master and its callers.
// Holds the FSM states, the response status codes and the PHY register word addresses.
package xaui_mgmt_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_GAP    = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_TIMEOUT   = 2'd1;
  localparam logic [1:0] ST_POLL_FAIL = 2'd2;

  // PHY register word addresses used by the board control FSM.
  localparam logic [8:0] PHY_ADDR_RESET_CTRL   = 9'h044;
  localparam logic [8:0] PHY_ADDR_RESET_STATUS = 9'h042;
  localparam logic [8:0] PHY_ADDR_LOCK_STATUS  = 9'h082;

endpackage

// File: rtl/xaui_mgmt_master.sv
// Avalon-MM initiator for the XAUI PHY management port: single read/write and
// masked polling with waitrequest timeout, all outputs registered.
module xaui_mgmt_master
  import xaui_mgmt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int POLL_MAX       = 256,
  parameter int POLL_GAP       = 16
) (
  input  logic        phy_mgmt_clk,
  input  logic        phy_mgmt_clk_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_poll,
  input  logic [8:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_mask,
  input  logic [31:0] cmd_expect,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_rdata,
  output logic [15:0] rsp_reads,
  output logic [8:0]  phy_mgmt_address,
  output logic        phy_mgmt_read,
  output logic        phy_mgmt_write,
  output logic [31:0] phy_mgmt_writedata,
  input  logic [31:0] phy_mgmt_readdata,
  input  logic        phy_mgmt_waitrequest
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

  state_e            state_q, state_d;
  logic              wr_q, wr_d, poll_q, poll_d;
  logic [8:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, mask_q, mask_d, exp_q, exp_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic              rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
  logic              cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [15:0]       rsp_reads_q, rsp_reads_d;

  logic accept, xfer_done, xfer_timeout, is_match, poll_last, gap_last;

  assign accept       = cmd_valid && cmd_ready_q;
  assign xfer_done    = (state_q == S_ACCESS) && !phy_mgmt_waitrequest;
  // Completion wins over timeout when waitrequest drops on the limit cycle.
  assign xfer_timeout = (state_q == S_ACCESS) && phy_mgmt_waitrequest && (wait_cnt_q == WAIT_LAST);
  assign is_match     = ((phy_mgmt_readdata ^ exp_q) & mask_q) == 32'd0;
  assign poll_last    = (poll_cnt_q == POLL_LAST);
  assign gap_last     = (gap_cnt_q == GAP_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge phy_mgmt_clk) begin
    if (phy_mgmt_clk_reset) state_q <= S_IDLE;
    else                    state_q <= state_d;
  end

  // NOTE: each combinational block assigns a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: begin
        if (xfer_done) state_d = (!poll_q || is_match || poll_last) ? S_RESP : S_GAP;
        else if (xfer_timeout) state_d = S_RESP;
      end
      S_GAP:    if (gap_last) state_d = S_ACCESS;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d         = wr_q;
    poll_d       = poll_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    exp_d        = exp_q;
    wait_cnt_d   = wait_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    rsp_status_d = rsp_status_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_reads_d  = rsp_reads_q;
    case (state_q)
      S_IDLE: if (accept) begin
        wr_d         = cmd_write;
        poll_d       = cmd_poll && !cmd_write;
        addr_d       = cmd_addr;
        wdata_d      = cmd_wdata;
        mask_d       = cmd_mask;
        exp_d        = cmd_expect;
        wait_cnt_d   = '0;
        gap_cnt_d    = '0;
        poll_cnt_d   = '0;
        rsp_status_d = ST_OK;
        rsp_rdata_d  = 32'd0;
        rsp_reads_d  = 16'd0;
      end
      S_ACCESS: begin
        if (xfer_done) begin
          gap_cnt_d = '0;
          if (!wr_q) begin
            rsp_rdata_d  = phy_mgmt_readdata;
            poll_cnt_d   = poll_cnt_q + POLL_W'(1);
            rsp_reads_d  = (rsp_reads_q == 16'hFFFF) ? rsp_reads_q : rsp_reads_q + 16'd1;
            rsp_status_d = (poll_q && !is_match && poll_last) ? ST_POLL_FAIL : ST_OK;
          end
        end else if (xfer_timeout) begin
          rsp_status_d = ST_TIMEOUT;
          rsp_rdata_d  = 32'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_last) wait_cnt_d = '0;
      end
      default: ;
    endcase
    // Registered strobes and handshakes follow the state being entered.
    rd_stb_d    = (state_d == S_ACCESS) && !wr_d;
    wr_stb_d    = (state_d == S_ACCESS) && wr_d;
    rsp_valid_d = (state_d == S_RESP);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge phy_mgmt_clk) begin
    if (phy_mgmt_clk_reset) begin
      wr_q         <= 1'b0;
      poll_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      exp_q        <= '0;
      wait_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      poll_cnt_q   <= '0;
      rd_stb_q     <= 1'b0;
      wr_stb_q     <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_rdata_q  <= '0;
      rsp_reads_q  <= '0;
    end else begin
      wr_q         <= wr_d;
      poll_q       <= poll_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      exp_q        <= exp_d;
      wait_cnt_q   <= wait_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      poll_cnt_q   <= poll_cnt_d;
      rd_stb_q     <= rd_stb_d;
      wr_stb_q     <= wr_stb_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_reads_q  <= rsp_reads_d;
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_status         = rsp_status_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_reads          = rsp_reads_q;
  assign phy_mgmt_address   = addr_q;
  assign phy_mgmt_read      = rd_stb_q;
  assign phy_mgmt_write     = wr_stb_q;
  assign phy_mgmt_writedata = wdata_q;

endmodule

// File: tb/tb_xaui_mgmt_master.sv
// Self-checking bench for xaui_mgmt_master: scripted/random slave behaviour
// compared against a command-level model of the expected bus and response.
module tb_xaui_mgmt_master;

  localparam int T  = 8;
  localparam int PM = 4;
  localparam int PG = 3;
  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_poll = 1'b0;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0, cmd_mask = '0, cmd_expect = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic [15:0] rsp_reads;
  logic [8:0]  phy_mgmt_address;
  logic        phy_mgmt_read, phy_mgmt_write;
  logic [31:0] phy_mgmt_writedata;
  logic [31:0] phy_mgmt_readdata = '0;
  logic        phy_mgmt_waitrequest = 1'b0;

  int checks = 0;
  int errors = 0;

  // Per-access slave script: stall cycles before completion, and data returned.
  int          stall_s[8];
  logic [31:0] data_s[8];

  always #5 clk = ~clk;

  xaui_mgmt_master #(.TIMEOUT_CYCLES(T), .POLL_MAX(PM), .POLL_GAP(PG)) dut (
    .phy_mgmt_clk        (clk),
    .phy_mgmt_clk_reset  (rst),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_write           (cmd_write),
    .cmd_poll            (cmd_poll),
    .cmd_addr            (cmd_addr),
    .cmd_wdata           (cmd_wdata),
    .cmd_mask            (cmd_mask),
    .cmd_expect          (cmd_expect),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_status          (rsp_status),
    .rsp_rdata           (rsp_rdata),
    .rsp_reads           (rsp_reads),
    .phy_mgmt_address    (phy_mgmt_address),
    .phy_mgmt_read       (phy_mgmt_read),
    .phy_mgmt_write      (phy_mgmt_write),
    .phy_mgmt_writedata  (phy_mgmt_writedata),
    .phy_mgmt_readdata   (phy_mgmt_readdata),
    .phy_mgmt_waitrequest(phy_mgmt_waitrequest)
  );

  // Issues one command, plays the scripted slave, and checks bus timing and response.
  task automatic run_cmd(input logic w, input logic p, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] m,
                         input logic [31:0] ev, input int bp, input string tag);
    int          n_acc, e_reads, idx, waited, len, cyc, rsp_cyc, cur_stall;
    logic [1:0]  e_status;
    logic [31:0] e_rdata;
    logic        done, active, got_rsp;
    int          start_c[8], len_c[8];

    // Reference model of the command outcome.
    n_acc = 0; e_reads = 0; e_status = 2'd0; e_rdata = 32'd0; done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      n_acc = i + 1;
      if (stall_s[i] >= T) begin
        e_status = 2'd1; e_rdata = 32'd0; done = 1'b1;
      end else if (w) begin
        done = 1'b1;
      end else begin
        e_reads = i + 1;
        e_rdata = data_s[i];
        if (!p || ((data_s[i] & m) == (ev & m))) done = 1'b1;
        else if (i + 1 == PM) begin e_status = 2'd2; done = 1'b1; end
      end
    end

    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s cmd_ready idle: got %b want 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_poll = p; cmd_addr = a;
    cmd_wdata = wd; cmd_mask = m; cmd_expect = ev;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_wdata = $urandom; cmd_addr = 9'($urandom);

    idx = 0; waited = 0; len = 0; cyc = 0; rsp_cyc = 0; active = 1'b0; got_rsp = 1'b0;
    for (int i = 0; i < 8; i++) begin start_c[i] = 0; len_c[i] = 0; end
    while (!got_rsp && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      phy_mgmt_readdata = $urandom;
      if (phy_mgmt_read && phy_mgmt_write) begin
        checks++; errors++;
        $display("FAIL %s strobes_both cyc %0d: read=1 write=1 want exclusive", tag, cyc);
      end
      if (phy_mgmt_read || phy_mgmt_write) begin
        if (!active) begin
          active = 1'b1; len = 0; waited = 0;
          if (idx < 8) start_c[idx] = cyc;
        end
        len++;
        checks++;
        if (phy_mgmt_write !== w || phy_mgmt_address !== a || (w && phy_mgmt_writedata !== wd)) begin
          errors++;
          $display("FAIL %s bus cyc %0d: wr=%b addr=%h wdata=%h want wr=%b addr=%h wdata=%h",
                   tag, cyc, phy_mgmt_write, phy_mgmt_address, phy_mgmt_writedata, w, a, wd);
        end
        cur_stall = (idx < 8) ? stall_s[idx] : 0;
        if (waited < cur_stall) begin
          phy_mgmt_waitrequest = 1'b1; waited++;
        end else begin
          phy_mgmt_waitrequest = 1'b0;
          phy_mgmt_readdata = (idx < 8) ? data_s[idx] : 32'd0;
        end
      end else begin
        phy_mgmt_waitrequest = 1'b0;
        if (active) begin
          if (idx < 8) len_c[idx] = len;
          idx++; active = 1'b0;
        end
      end
      if (rsp_valid) begin got_rsp = 1'b1; rsp_cyc = cyc; end
    end

    checks++;
    if (!got_rsp) begin
      errors++; $display("FAIL %s rsp_timeout: no rsp_valid within %0d cycles", tag, BUDGET);
    end
    checks++;
    if (idx != n_acc) begin
      errors++; $display("FAIL %s access_count: got %0d want %0d", tag, idx, n_acc);
    end
    for (int i = 0; i < n_acc && i < idx; i++) begin
      checks++;
      if (len_c[i] != ((stall_s[i] >= T) ? T : stall_s[i] + 1)) begin
        errors++; $display("FAIL %s strobe_len[%0d]: got %0d want %0d", tag, i, len_c[i],
                           (stall_s[i] >= T) ? T : stall_s[i] + 1);
      end
      checks++;
      if (i == 0 && start_c[0] != 1) begin
        errors++; $display("FAIL %s first_strobe: got cycle %0d want 1", tag, start_c[0]);
      end else if (i > 0 && start_c[i] - start_c[i-1] != PG + 1 + stall_s[i-1]) begin
        errors++; $display("FAIL %s read_spacing[%0d]: got %0d want %0d", tag, i,
                           start_c[i] - start_c[i-1], PG + 1 + stall_s[i-1]);
      end
    end
    if (idx > 0 && idx <= 8) begin
      checks++;
      if (rsp_cyc != start_c[idx-1] + len_c[idx-1]) begin
        errors++; $display("FAIL %s rsp_latency: got cycle %0d want %0d", tag, rsp_cyc,
                           start_c[idx-1] + len_c[idx-1]);
      end
    end

    for (int k = 0; k <= bp; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_status !== e_status || rsp_rdata !== e_rdata ||
          rsp_reads !== 16'(e_reads)) begin
        errors++;
        $display("FAIL %s rsp hold %0d: valid=%b status=%0d rdata=%h reads=%0d want 1 %0d %h %0d",
                 tag, k, rsp_valid, rsp_status, rsp_rdata, rsp_reads, e_status, e_rdata, e_reads);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s after_handshake: rsp_valid=%b cmd_ready=%b want 0 1",
                         tag, rsp_valid, cmd_ready);
    end
  endtask

  task automatic clear_script();
    for (int i = 0; i < 8; i++) begin stall_s[i] = 0; data_s[i] = 32'd0; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || phy_mgmt_read !== 1'b0 || phy_mgmt_write !== 1'b0 ||
        rsp_status !== 2'd0 || rsp_rdata !== 32'd0 || rsp_reads !== 16'd0 ||
        phy_mgmt_address !== 9'd0 || phy_mgmt_writedata !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b rd=%b wr=%b st=%0d rdata=%h reads=%0d addr=%h wd=%h want all 0",
               cmd_ready, rsp_valid, phy_mgmt_read, phy_mgmt_write, rsp_status, rsp_rdata,
               rsp_reads, phy_mgmt_address, phy_mgmt_writedata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    clear_script();
    run_cmd(1'b1, 1'b0, 9'h044, 32'h0000_0001, 32'd0, 32'd0, 0, "write");
    stall_s[0] = 2;
    run_cmd(1'b1, 1'b1, 9'h1A5, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'd0, 1, "write_poll_ignored");
  endtask

  task automatic test_read_stall();
    clear_script();
    stall_s[0] = 5; data_s[0] = 32'hDEAD_BEEF;
    run_cmd(1'b0, 1'b0, 9'h082, 32'd0, 32'd0, 32'd0, 0, "read_stall");
  endtask

  task automatic test_poll();
    clear_script();
    data_s[0] = 32'h0; data_s[1] = 32'h0; data_s[2] = 32'h1;
    run_cmd(1'b0, 1'b1, 9'h082, 32'd0, 32'h1, 32'h1, 0, "poll_success");
    clear_script();
    stall_s[1] = 2;
    run_cmd(1'b0, 1'b1, 9'h082, 32'd0, 32'h1, 32'h1, 2, "poll_fail");
  endtask

  task automatic test_timeout();
    clear_script();
    stall_s[0] = 1000;
    run_cmd(1'b0, 1'b0, 9'h042, 32'd0, 32'd0, 32'd0, 0, "timeout_read");
    clear_script();
    stall_s[0] = T - 1;
    data_s[0] = 32'h1234_5678;
    run_cmd(1'b0, 1'b0, 9'h042, 32'd0, 32'd0, 32'd0, 0, "timeout_boundary");
    clear_script();
    data_s[0] = 32'h0; stall_s[1] = T;
    run_cmd(1'b0, 1'b1, 9'h082, 32'd0, 32'h4, 32'h4, 0, "poll_then_timeout");
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_poll = 1'b0; cmd_addr = 9'h082;
    phy_mgmt_waitrequest = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (phy_mgmt_read !== 1'b1) begin
      errors++; $display("FAIL mid_reset stalled_read: read=%b want 1", phy_mgmt_read);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (phy_mgmt_read !== 1'b0 || phy_mgmt_write !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset outputs: rd=%b wr=%b valid=%b ready=%b want 0 0 0 0",
                         phy_mgmt_read, phy_mgmt_write, rsp_valid, cmd_ready);
    end
    rst = 1'b0;
    phy_mgmt_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset recover cmd_ready: got %b want 1", cmd_ready);
    end
    clear_script();
    stall_s[0] = 2; data_s[0] = 32'hA5A5_0F0F;
    run_cmd(1'b0, 1'b0, 9'h082, 32'd0, 32'd0, 32'd0, 4, "after_reset_backpressure");
  endtask

  task automatic test_random();
    logic        w, p;
    logic [31:0] m, ev;
    for (int n = 0; n < 40; n++) begin
      w  = ($urandom_range(0, 2) == 0);
      p  = $urandom_range(0, 1) == 1;
      m  = $urandom;
      ev = $urandom;
      for (int i = 0; i < 8; i++) begin
        stall_s[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 3);
        data_s[i]  = ($urandom_range(0, 2) == 0) ? ((ev & m) | ($urandom & ~m)) : $urandom;
      end
      run_cmd(w, p, 9'($urandom), $urandom, m, ev, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    clear_script();
    test_reset();
    test_write();
    test_read_stall();
    test_poll();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
